// File: rtl/siso_delay_line.sv
// siso_delay_line: word-wide delay line with runtime-selectable delay 0..DEPTH, shift enable, valid tracking and occupancy count
// clk/rst_n : rising-edge clock, asynchronous active-low reset
// en, clr   : shift enable; synchronous clear (wins over en)
// in_valid, din         : input word and its qualifier
// delay_sel             : requested delay, values above DEPTH clamp to DEPTH, 0 bypasses
// dout, out_valid       : delayed word and qualifier (combinational mux of the stages)
// fill_cnt              : number of valid stages (registered)
module siso_delay_line #(
  parameter int DATA_WID = 8,
  parameter int DEPTH    = 5,
  parameter int SEL_WID  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                clr,
  input  logic                in_valid,
  input  logic [DATA_WID-1:0] din,
  input  logic [SEL_WID-1:0]  delay_sel,
  output logic [DATA_WID-1:0] dout,
  output logic                out_valid,
  output logic [SEL_WID-1:0]  fill_cnt
);
  logic [DATA_WID-1:0] stage [DEPTH];
  logic [DATA_WID-1:0] nxt   [DEPTH];
  logic [DEPTH-1:0]    vld;
  logic [DEPTH-1:0]    vld_nxt;
  logic [SEL_WID-1:0]  d_eff;
  assign d_eff = (delay_sel > SEL_WID'(DEPTH)) ? SEL_WID'(DEPTH) : delay_sel;
  // invalid slots carry zero data so a bubble is always 0 on dout
  assign nxt[0]     = in_valid ? din : '0;
  assign vld_nxt[0] = in_valid;
  genvar k;
  generate
    for (k = 1; k < DEPTH; k++) begin : g_shift
      assign nxt[k]     = stage[k-1];
      assign vld_nxt[k] = vld[k-1];
    end
    for (k = 0; k < DEPTH; k++) begin : g_stage
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          stage[k] <= '0;
          vld[k]   <= 1'b0;
        end else if (clr) begin
          stage[k] <= '0;
          vld[k]   <= 1'b0;
        end else if (en) begin
          stage[k] <= nxt[k];
          vld[k]   <= vld_nxt[k];
        end
    end
  endgenerate
  // the word leaving the last stage is the only way occupancy drops
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fill_cnt <= '0;
    else if (clr) fill_cnt <= '0;
    else if (en) fill_cnt <= fill_cnt + SEL_WID'(in_valid) - SEL_WID'(vld[DEPTH-1]);
  always_comb begin
    dout      = din;
    out_valid = in_valid;
    for (int i = 0; i < DEPTH; i++)
      if (d_eff == SEL_WID'(i + 1)) begin
        dout      = stage[i];
        out_valid = vld[i];
      end
  end
endmodule

// File: tb/tb_siso_delay_line.sv
// tb_siso_delay_line: scoreboard bench for siso_delay_line with directed vectors
module tb_siso_delay_line;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] din = '0;
  logic [2:0] delay_sel = 3'd3;
  logic [7:0] dout;
  logic       out_valid;
  logic [2:0] fill_cnt;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] q [$];
  bit         mon_on = 1'b0;
  logic       pv [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [7:0] pd [4] = '{8'hA1, 8'h77, 8'hB2, 8'hC3};
  siso_delay_line #(.DATA_WID(8), .DEPTH(5), .SEL_WID(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in_valid(in_valid), .din(din),
    .delay_sel(delay_sel), .dout(dout), .out_valid(out_valid), .fill_cnt(fill_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic e, input logic iv, input logic [7:0] d);
    en = e;
    in_valid = iv;
    din = d;
    if (mon_on && e && iv) q.push_back(d);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // a word leaves the line once per enabled cycle in which out_valid is high
  always @(negedge clk)
    if (rst_n && mon_on && en && out_valid) begin
      if (q.size() == 0) chk("sb_unexpected_word", {24'd0, dout}, 32'hFFFF_FFFF);
      else chk("sb_data", {24'd0, dout}, {24'd0, q.pop_front()});
    end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    #12;
    chk("rst_dout", dout, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_fill", fill_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    // D=3 incrementing stream
    mon_on = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 8'(i + 1));
      #1;
      if (i < 3) chk("d3_early_valid", out_valid, 0);
      if (i == 3) begin
        chk("d3_first_dout", dout, 8'h01);
        chk("d3_first_valid", out_valid, 1);
      end
      if (i == 5) chk("d3_fill_full", fill_cnt, 5);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 8'h00);
      tick();
    end
    chk("d3_fill_drained", fill_cnt, 0);
    chk("d3_sb_empty", q.size(), 0);
    mon_on = 1'b0;
    // bypass
    delay_sel = 3'd0;
    drive(1'b0, 1'b1, 8'hA5);
    #1;
    chk("bypass_dout", dout, 8'hA5);
    chk("bypass_valid", out_valid, 1);
    drive(1'b0, 1'b0, 8'h5A);
    #1;
    chk("bypass_invalid", out_valid, 0);
    chk("bypass_dout2", dout, 8'h5A);
    tick();
    // delay_sel above DEPTH clamps to 5
    delay_sel = 3'd7;
    mon_on = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, i == 0, (i == 0) ? 8'h01 : 8'h00);
      #1;
      chk("d7_valid", out_valid, i == 5);
      tick();
    end
    chk("d7_fill", fill_cnt, 0);
    chk("d7_sb_empty", q.size(), 0);
    // bubble pattern at D=2
    delay_sel = 3'd2;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) drive(1'b1, pv[i], pd[i]);
      else drive(1'b1, 1'b0, 8'h00);
      #1;
      if (i == 3) begin
        chk("bubble_dout", dout, 0);
        chk("bubble_valid", out_valid, 0);
      end
      if (i == 4) chk("bubble_fill3", fill_cnt, 3);
      if (i == 6) chk("bubble_fill2", fill_cnt, 2);
      if (i == 9) chk("bubble_fill0", fill_cnt, 0);
      tick();
    end
    chk("bubble_sb_empty", q.size(), 0);
    // hold with en=0 for 3 cycles, re-muxing the frozen stages
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 8'(8'h10 + i));
      tick();
    end
    drive(1'b0, 1'b1, 8'hEE);
    #1;
    chk("hold_dout", dout, 8'h11);
    chk("hold_valid", out_valid, 1);
    tick();
    delay_sel = 3'd1;
    #1;
    chk("hold_remux_d1", dout, 8'h12);
    tick();
    delay_sel = 3'd2;
    #1;
    chk("hold_remux_d2", dout, 8'h11);
    chk("hold_fill", fill_cnt, 3);
    tick();
    drive(1'b1, 1'b0, 8'h00);
    #1;
    chk("hold_resume_dout", dout, 8'h11);
    chk("hold_resume_valid", out_valid, 1);
    tick();
    for (int i = 0; i < 5; i++) tick();
    chk("hold_fill0", fill_cnt, 0);
    chk("hold_sb_empty", q.size(), 0);
    mon_on = 1'b0;
    // fill all stages, then clr together with en
    delay_sel = 3'd5;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 8'(8'h21 + i));
      tick();
    end
    #1;
    chk("clr_fill5", fill_cnt, 5);
    clr = 1'b1;
    drive(1'b1, 1'b1, 8'hFF);
    tick();
    clr = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    #1;
    chk("clr_fill0", fill_cnt, 0);
    for (int d = 1; d <= 5; d++) begin
      delay_sel = 3'(d);
      #1;
      chk("clr_valid", out_valid, 0);
      chk("clr_dout", dout, 0);
    end
    delay_sel = 3'd1;
    drive(1'b1, 1'b0, 8'h00);
    tick();
    #1;
    chk("clr_ff_not_captured", out_valid, 0);
    // async reset mid-stream
    delay_sel = 3'd4;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 8'(8'h31 + i));
      tick();
    end
    drive(1'b0, 1'b0, 8'h00);
    #1;
    chk("arst_fill4", fill_cnt, 4);
    chk("arst_pre_dout", dout, 8'h31);
    chk("arst_pre_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_fill", fill_cnt, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_dout", dout, 0);
    #3;
    rst_n = 1'b1;
    tick();
    mon_on = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, i == 0, (i == 0) ? 8'h41 : 8'h00);
      #1;
      chk("arst_relat_valid", out_valid, i == 4);
      tick();
    end
    chk("arst_sb_empty", q.size(), 0);
    mon_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/siso_delay_line.md
Name: siso_delay_line

Overview:
- Parametrised word-wide serial-in/serial-out delay line; successor to the fixed 5-stage shift register.
- Adds runtime-selectable delay (0..DEPTH), shift enable, per-stage valid tracking, synchronous clear and an occupancy count.
- Used to align data streams with pipelines of differing latency inside the datapath.

Parameters:
- DATA_WID, 8, width of each data word.
- DEPTH, 5, number of storage stages = maximum delay in enabled cycles (>= 1).
- SEL_WID, 3, width of delay_sel and fill_cnt; must satisfy 2^SEL_WID > DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  shift enable; stages advance only on edges where en=1.
- clr  input  1  synchronous clear of all stages; priority over en.
- in_valid  input  1  din qualifier.
- din  input  DATA_WID  input word.
- delay_sel  input  SEL_WID  requested delay D; 0 = bypass.
- dout  output  DATA_WID  delayed word (combinational mux of stages).
- out_valid  output  1  dout qualifier.
- fill_cnt  output  SEL_WID  count of valid stages, 0..DEPTH (registered).

Behaviour:
- Storage: stage[0..DEPTH-1] of DATA_WID bits, each with a valid bit vld[k].
- Reset (rst_n=0, async): all stage data=0, all vld=0, fill_cnt=0. Hence dout=0 and out_valid=0 for any D>=1; for D=0, dout/out_valid follow din/in_valid.
- Release of reset has no effect until the first rising edge with rst_n=1.
- Priority per rising edge: clr > en > hold.
- clr=1: stage data=0, vld=0, fill_cnt=0, regardless of en.
- en=1, clr=0, shifting:
  - stage[0] <= in_valid ? din : 0; vld[0] <= in_valid.
  - stage[k] <= stage[k-1] and vld[k] <= vld[k-1] for k=1..DEPTH-1.
  - stage[DEPTH-1] contents are discarded.
  - Invalid slots carry zero data (deterministic for the checker).
- en=0, clr=0: all stages, vld bits and fill_cnt hold.
- Effective delay Deff = min(delay_sel, DEPTH).
  - Deff=0: dout=din, out_valid=in_valid (pure combinational bypass; stages still shift per en).
  - Deff>=1: dout=stage[Deff-1], out_valid=vld[Deff-1].
- Latency: with en held 1, a word presented in cycle t appears on dout in cycle t+Deff. Each en=0 cycle adds one cycle of latency.
- delay_sel changes take effect combinationally in the same cycle. There is no flush; words already in flight are neither duplicated nor dropped inside the line. Output continuity across a change is the user's responsibility; out_valid stays truthful.
- Changing delay_sel while en=0 re-muxes dout from the frozen stages.
- fill_cnt:
  - On an en=1, clr=0 edge: fill_cnt <= fill_cnt + in_valid - vld[DEPTH-1].
  - Range 0..DEPTH; never wraps by construction.
  - Unchanged when en=0.
- Simultaneous clr and en: clr wins; the incoming word is lost and fill_cnt=0.
- Reset asserted mid-stream: immediate clear as above. No partial state survives.
- No X on outputs after reset for any delay_sel value, including values > DEPTH.

Test Plan:
- Reset, then en=1, in_valid=1, din=0x01,0x02,0x03... each cycle, delay_sel=3: dout=0x01 with out_valid=1 in the 3rd cycle after 0x01 is presented, then increments each cycle; out_valid=0 before that.
- delay_sel=0, din=0xA5, in_valid=1: dout=0xA5, out_valid=1 in the same cycle. delay_sel=7 (>DEPTH): behaves as D=5 (0x01 emerges 5 cycles after presentation).
- Stream with in_valid pattern 1,0,1,1 and en=1, D=2: out_valid pattern 1,0,1,1 delayed by 2 cycles, with dout=0x00 in the bubble. fill_cnt reaches 3, then decrements as valid words leave stage 4.
- Hold en=0 for 3 cycles mid-stream: dout/out_valid frozen, fill_cnt frozen; latency of in-flight words grows by 3. Toggling delay_sel during the hold re-selects from the frozen stages.
- Fill all 5 stages valid (fill_cnt=5), then assert clr together with en=1, din=0xFF: next cycle fill_cnt=0, out_valid=0 for every D>=1, 0xFF is not captured.
- Assert rst_n=0 asynchronously between clock edges with fill_cnt=4: outputs clear immediately without a clock edge. After release, the first word again needs Deff cycles.
